// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// SHIFTER_STATUS_EN adds a carry bit to the per-stage control bundle.
package shifter_pkg;

  typedef enum logic [2:0] {
    LSL = 3'd0,
    LSR = 3'd1,
    ASR = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_mode_t;

  typedef struct packed {
    logic        valid;
    shift_mode_t mode;
`ifdef SHIFTER_STATUS_EN
    logic        carry;
`endif
  } stage_ctl_t;

  function automatic stage_ctl_t head_ctl(
    input logic       valid,
    input logic [2:0] mode
  );
    head_ctl       = '0;
    head_ctl.valid = valid;
    head_ctl.mode  = shift_mode_t'(mode);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditional shift/rotate by 2**K, then a register.
// SHIFTER_STATUS_EN tracks the last bit moved across the word boundary.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            advance,
  input  logic [2**N-1:0] prev_data,
  input  logic [N-1:0]    prev_amt,
  input  stage_ctl_t      prev_ctl,
  output logic [2**N-1:0] data,
  output logic [N-1:0]    amt,
  output stage_ctl_t      ctl
);

  localparam int W = 2**N;
  localparam int S = 2**K;

  logic [W-1:0] shifted;
  stage_ctl_t   next_ctl;
`ifdef SHIFTER_STATUS_EN
  logic         legal;
`endif

  always_comb begin
    shifted  = prev_data;
    next_ctl = prev_ctl;
    if (prev_amt[K]) begin
      unique case (1'b1)
        prev_ctl.mode == LSL:
          shifted = prev_data << S;
        prev_ctl.mode == LSR:
          shifted = prev_data >> S;
        prev_ctl.mode == ASR:
          shifted = W'($signed(prev_data) >>> S);
        prev_ctl.mode == ROL:
          shifted = {prev_data[W-S-1:0],
                     prev_data[W-1:W-S]};
        prev_ctl.mode == ROR:
          shifted = {prev_data[S-1:0],
                     prev_data[W-1:S]};
        default:
          shifted = prev_data;
      endcase
    end
`ifdef SHIFTER_STATUS_EN
    legal = prev_ctl.mode inside
            {LSL, LSR, ASR, ROL, ROR};
    // Leftward moves lose bit W-S, rightward lose bit S-1.
    if (prev_amt[K] && legal) begin
      if (prev_ctl.mode == LSL ||
          prev_ctl.mode == ROL)
        next_ctl.carry = prev_data[W-S];
      else
        next_ctl.carry = prev_data[S-1];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data <= '0;
      amt  <= '0;
      ctl  <= '0;
    end else if (advance) begin
      data <= shifted;
      amt  <= prev_amt;
      ctl  <= next_ctl;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// N-stage valid/ready barrel shifter: LSL, LSR, ASR, ROL, ROR.
// Define SHIFTER_STATUS_EN to add the zero and carry outputs.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2**N-1:0] a,
  input  logic [N-1:0]    amt,
  input  logic [2:0]      mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] y
`ifdef SHIFTER_STATUS_EN
  ,
  output logic            zero,
  output logic            carry
`endif
);

  localparam int W = 2**N;

  logic         advance;
  logic [W-1:0] data_s [N+1];
  logic [N-1:0] amt_s  [N+1];
  stage_ctl_t   ctl_s  [N+1];
  logic         unused_tail;

  // Whole pipe moves together; only a blocked output stalls it.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign data_s[0] = a;
  assign amt_s[0]  = amt;
  assign ctl_s[0]  = head_ctl(in_valid, mode);

  for (genvar k = 0; k < N; k++) begin : g_stage
    shift_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .advance   (advance),
      .prev_data (data_s[k]),
      .prev_amt  (amt_s[k]),
      .prev_ctl  (ctl_s[k]),
      .data      (data_s[k+1]),
      .amt       (amt_s[k+1]),
      .ctl       (ctl_s[k+1])
    );
  end

  assign out_valid = ctl_s[N].valid;
  assign y         = data_s[N];

`ifdef SHIFTER_STATUS_EN
  assign zero  = out_valid && (y == '0);
  assign carry = ctl_s[N].carry;
`endif

  assign unused_tail = ^{amt_s[N], ctl_s[N].mode};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter at N=3,4,5 with a scoreboard model.
// Status flags are checked when SHIFTER_STATUS_EN is defined.
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [31:0] a    [3];
  logic [31:0] y    [3];
  logic [4:0]  amt  [3];
  logic [2:0]  md   [3];
`ifdef SHIFTER_STATUS_EN
  logic        zf   [3];
  logic        cf   [3];
`endif
  int          nout  [3];
  int          npush [3];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Whole-amount reference: {carry, result}
  function automatic logic [32:0] model(
    input int          n,
    input logic [31:0] ai,
    input logic [4:0]  am,
    input logic [2:0]  m
  );
    int          w;
    int          s;
    logic [63:0] mk;
    logic [63:0] av;
    logic [63:0] r;
    logic        c;
    w  = 1 << n;
    mk = (64'd1 << w) - 64'd1;
    av = {32'd0, ai} & mk;
    s  = int'(am) % w;
    r  = av;
    c  = 1'b0;
    case (m)
      3'd0: begin
        r = (av << s) & mk;
        if (s != 0) c = av[w-s];
      end
      3'd1: begin
        r = av >> s;
        if (s != 0) c = av[s-1];
      end
      3'd2: begin
        r = av >> s;
        if (av[w-1]) r = r | (mk & ~(mk >> s));
        if (s != 0) c = av[s-1];
      end
      3'd3: begin
        r = ((av << s) | (av >> (w - s))) & mk;
        if (s != 0) c = r[0];
      end
      3'd4: begin
        r = ((av >> s) | (av << (w - s))) & mk;
        if (s != 0) c = r[w-1];
      end
      default: ;
    endcase
    return {c, r[31:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NN = g + 3;
    localparam int WW = 1 << NN;
    logic [32:0]   q[$];
    logic          stall_q;
    logic [WW-1:0] y_q;

    pipelined_barrel_shifter #(.N(NN)) u_dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .a         (a[g][WW-1:0]),
      .amt       (amt[g][NN-1:0]),
      .mode      (md[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .y         (y[g][WW-1:0])
`ifdef SHIFTER_STATUS_EN
      ,
      .zero      (zf[g]),
      .carry     (cf[g])
`endif
    );

    always @(negedge clk) begin
      logic [32:0] e;
      if (!rst_n) begin
        q.delete();
        stall_q = 1'b0;
      end else begin
        chk($sformatf("ready_n%0d", NN), ir[g],
            !ov[g] || ordy[g]);
        if (stall_q) begin
          chk($sformatf("hold_valid_n%0d", NN), ov[g], 1);
          chk($sformatf("hold_y_n%0d", NN),
              y[g][WW-1:0], y_q);
        end
        if (ov[g] && ordy[g]) begin
          nout[g]++;
          chk($sformatf("out_expected_n%0d", NN),
              q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("y_n%0d", NN),
                y[g][WW-1:0], e[WW-1:0]);
`ifdef SHIFTER_STATUS_EN
            chk($sformatf("carry_n%0d", NN), cf[g], e[32]);
            chk($sformatf("zero_n%0d", NN), zf[g],
                e[WW-1:0] == '0);
`endif
          end
        end
        if (iv[g] && ir[g]) begin
          npush[g]++;
          q.push_back(model(NN, a[g], amt[g], md[g]));
        end
        stall_q = ov[g] && !ordy[g];
        y_q     = y[g][WW-1:0];
      end
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [2:0] amt;
    logic [2:0] md;
    logic [7:0] y;
    logic       c;
    logic       z;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic acc;
    logic ac [3];
    int   bound;
    int   n0;
    int   p0;

    tbl[0]  = '{8'h96, 3'd3, 3'd0, 8'hB0, 1'b0, 1'b0};
    tbl[1]  = '{8'h96, 3'd3, 3'd1, 8'h12, 1'b1, 1'b0};
    tbl[2]  = '{8'h96, 3'd3, 3'd2, 8'hF2, 1'b1, 1'b0};
    tbl[3]  = '{8'h96, 3'd3, 3'd3, 8'hB4, 1'b0, 1'b0};
    tbl[4]  = '{8'h96, 3'd3, 3'd4, 8'hD2, 1'b1, 1'b0};
    tbl[5]  = '{8'hA5, 3'd0, 3'd0, 8'hA5, 1'b0, 1'b0};
    tbl[6]  = '{8'hA5, 3'd0, 3'd1, 8'hA5, 1'b0, 1'b0};
    tbl[7]  = '{8'hA5, 3'd0, 3'd2, 8'hA5, 1'b0, 1'b0};
    tbl[8]  = '{8'hA5, 3'd0, 3'd3, 8'hA5, 1'b0, 1'b0};
    tbl[9]  = '{8'hA5, 3'd0, 3'd4, 8'hA5, 1'b0, 1'b0};
    tbl[10] = '{8'hA5, 3'd5, 3'd7, 8'hA5, 1'b0, 1'b0};
    tbl[11] = '{8'h01, 3'd1, 3'd1, 8'h00, 1'b1, 1'b1};
    tbl[12] = '{8'h80, 3'd7, 3'd2, 8'hFF, 1'b0, 1'b0};
    tbl[13] = '{8'h81, 3'd1, 3'd3, 8'h03, 1'b1, 1'b0};
    tbl[14] = '{8'hFF, 3'd7, 3'd1, 8'h01, 1'b1, 1'b0};

    for (int g = 0; g < 3; g++) begin
      iv[g] = 0; ordy[g] = 1; a[g] = '0;
      amt[g] = '0; md[g] = '0;
      nout[g] = 0; npush[g] = 0; ac[g] = 0;
    end
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("rst_out_valid%0d", g), ov[g], 0);
    chk("rst_y", y[0][7:0], 8'h00);
    chk("rst_in_ready", ir[0], 1);
`ifdef SHIFTER_STATUS_EN
    chk("rst_zero", zf[0], 0);
    chk("rst_carry", cf[0], 0);
`endif
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Table: back-to-back ops, each result exactly 3 cycles later
    fork
      begin
        for (int i = 0; i < 15; i++) begin
          iv[0] = 1;
          a[0] = {24'd0, tbl[i].a};
          amt[0] = {2'd0, tbl[i].amt};
          md[0] = tbl[i].md;
          @(posedge clk); #1;
        end
        iv[0] = 0;
      end
      begin
        @(posedge clk);
        @(negedge clk);
        chk("lat_early0", ov[0], 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_early1", ov[0], 0);
        for (int i = 0; i < 15; i++) begin
          @(posedge clk);
          @(negedge clk);
          chk($sformatf("tbl%0d_valid", i), ov[0], 1);
          chk($sformatf("tbl%0d_y", i), y[0][7:0], tbl[i].y);
`ifdef SHIFTER_STATUS_EN
          chk($sformatf("tbl%0d_carry", i), cf[0], tbl[i].c);
          chk($sformatf("tbl%0d_zero", i), zf[0], tbl[i].z);
`endif
        end
      end
    join
    repeat (5) @(posedge clk); #1;

    // Backpressure: 6 ops, consumer stalls for 4 cycles mid-stream
    n0 = nout[0];
    p0 = npush[0];
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          iv[0] = 1;
          a[0] = $urandom;
          amt[0] = 5'($urandom_range(0, 7));
          md[0] = 3'($urandom_range(0, 4));
          bound = 0;
          do begin
            @(negedge clk);
            acc = ir[0];
            @(posedge clk); #1;
            bound++;
          end while (!acc && bound < 50);
          chk($sformatf("bp_accept%0d", i), acc, 1);
        end
        iv[0] = 0;
      end
      begin
        repeat (2) @(posedge clk); #1;
        ordy[0] = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_stall_valid", ov[0], 1);
        chk("bp_stall_ready", ir[0], 0);
        repeat (2) @(posedge clk); #1;
        ordy[0] = 1;
      end
    join
    repeat (15) @(posedge clk); #1;
    chk("bp_pushed", npush[0] - p0, 6);
    chk("bp_delivered", nout[0] - n0, 6);

    // Reset with two operations in flight
    n0 = nout[0];
    iv[0] = 1; a[0] = 32'h5A; amt[0] = 5'd1; md[0] = 3'd0;
    @(posedge clk); #1;
    a[0] = 32'h3C; amt[0] = 5'd2; md[0] = 3'd4;
    @(posedge clk); #1;
    iv[0] = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_mid_valid", ov[0], 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rst_stale%0d", i), ov[0], 0);
    end
    chk("rst_no_output", nout[0] - n0, 0);
    @(posedge clk); #1;

    // Random sweep on all three widths
    for (int g = 0; g < 3; g++) begin
      nout[g] = 0; npush[g] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int g = 0; g < 3; g++) begin
        if (!iv[g] || ac[g]) begin
          int w;
          w = 1 << (g + 3);
          iv[g] = $urandom_range(0, 3) != 0;
          a[g] = $urandom;
          if ($urandom_range(0, 3) == 0)
            amt[g] = 5'(w - 1);
          else
            amt[g] = 5'($urandom_range(0, w - 1));
          md[g] = 3'($urandom_range(0, 7));
        end
        ordy[g] = $urandom_range(0, 9) < 7;
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        ac[g] = iv[g] && ir[g];
      @(posedge clk); #1;
    end
    for (int g = 0; g < 3; g++) begin
      iv[g] = 0; ordy[g] = 1;
    end
    repeat (20) @(posedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rnd_drained%0d", g), nout[g], npush[g]);
      chk($sformatf("rnd_active%0d", g), npush[g] > 100, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
